// File: rtl/madd_pkg.sv
// Shared definitions for the column-truncated multiply-add unit:
// result-width derivation, parameter range check and a bit-level
// reference function used by RTL assertions and the bench.
package madd_pkg;

  localparam int MAX_W = 16;
  localparam int REF_W = 2 * MAX_W;

  function automatic int out_w_of(input int w);
    return 2 * w;
  endfunction

  function automatic bit trunc_in_range(input int w, input int trunc);
    return (w >= 1) && (w <= MAX_W) && (trunc >= 0) && (trunc < out_w_of(w));
  endfunction

  // Sum of partial-product bits in columns >= trunc, plus c with its low trunc bits cleared.
  function automatic logic [REF_W-1:0] trunc_madd(input logic [MAX_W-1:0] a,
                                                  input logic [MAX_W-1:0] b,
                                                  input logic [MAX_W-1:0] c,
                                                  input int trunc);
    logic [REF_W-1:0] acc;
    logic [REF_W-1:0] keep;
    acc  = '0;
    keep = {REF_W{1'b1}} << trunc;
    for (int i = 0; i < MAX_W; i++) begin
      for (int j = 0; j < MAX_W; j++) begin
        if (a[i] && b[j] && ((i + j) >= trunc)) begin
          acc = acc + (REF_W'(1) << (i + j));
        end
      end
    end
    return acc + ({{(REF_W - MAX_W){1'b0}}, c} & keep);
  endfunction

endpackage

// File: rtl/madd_trunc_pp.sv
// Combinational partial-product array with the lowest TRUNC result
// columns removed. Output P is OUT_W = 2*W bits wide.
module madd_trunc_pp
  import madd_pkg::*;
#(
  parameter int W     = 6,
  parameter int TRUNC = 4,
  localparam int OUT_W = out_w_of(W)
) (
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [OUT_W-1:0] p
);

  logic [REF_W-1:0] p_ref;

  // accumulate every a[i]&b[j] whose weight column survives truncation
  always_comb begin
    p = '0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        if ((i + j) >= TRUNC) begin
          p = p + ({{(OUT_W - 1){1'b0}}, a[i] & b[j]} << (i + j));
        end
      end
    end
  end

  // cross-check the array against the shared reference model
  always_comb begin
    p_ref = trunc_madd(MAX_W'(a), MAX_W'(b), '0, TRUNC);
    assert (p_ref == REF_W'(p));
  end

endmodule

// File: rtl/madd_trunc_pipe.sv
// Two-stage approximate multiply-add y ~= a*b + c with valid/ready
// handshake on both sides. Stage 1 holds the truncated product and the
// masked addend; stage 2 is the output register. Accumulate mode
// (running sum in place of c, sticky wrap flag) is built only when
// MADD_TRUNC_ACC_EN is defined; otherwise in_acc/acc_clr are ignored
// and acc_ovf is tied low.
module madd_trunc_pipe
  import madd_pkg::*;
#(
  parameter int W     = 6,
  parameter int TRUNC = 4,
  localparam int OUT_W = out_w_of(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W-1:0]     in_c,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_y,
  output logic             acc_ovf
);

  localparam bit TRUNC_OK = trunc_in_range(W, TRUNC);
  localparam logic [OUT_W-1:0] KEEP_MASK = {OUT_W{1'b1}} << TRUNC;

  if (!TRUNC_OK) begin : g_bad_trunc
    $error("madd_trunc_pipe: TRUNC must lie in 0..2*W-1");
  end

  logic [OUT_W-1:0] pp;
  logic [OUT_W-1:0] ct_in;
  logic [OUT_W-1:0] s1_p;
  logic [OUT_W-1:0] s1_ct;
  logic             s1_valid;
  logic             accept;
  logic             s2_load;
  logic [OUT_W-1:0] y_next;

  madd_trunc_pp #(
    .W     (W),
    .TRUNC (TRUNC)
  ) u_pp (
    .a (in_a),
    .b (in_b),
    .p (pp)
  );

  assign ct_in    = {{(OUT_W - W){1'b0}}, in_c} & KEEP_MASK;
  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  // stage 1 moves on whenever the output register is empty or draining
  assign s2_load  = s1_valid && (!out_valid || out_ready);

  // stage 1: capture product and addend of an accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_ct    <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_p     <= pp;
      s1_ct    <= ct_in;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // stage 2: output register, held while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out_y     <= y_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MADD_TRUNC_ACC_EN
  logic             s1_acc;
  logic [OUT_W-1:0] acc;
  logic [OUT_W:0]   acc_sum;
  logic             acc_ovf_q;

  assign acc_sum = {1'b0, s1_p} + {1'b0, acc};
  assign acc_ovf = acc_ovf_q;

  // P + Ct never carries out of OUT_W bits; the running sum may wrap
  always_comb begin
    y_next = s1_acc ? acc_sum[OUT_W-1:0] : (s1_p + s1_ct);
  end

  // mode bit travels with its beat through stage 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_acc <= 1'b0;
    end else if (accept) begin
      s1_acc <= in_acc;
    end
  end

  // accumulator: clear beats a same-cycle load, which still saw the old value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      acc_ovf_q <= 1'b0;
    end else if (acc_clr) begin
      acc       <= '0;
      acc_ovf_q <= 1'b0;
    end else if (s2_load && s1_acc) begin
      acc <= acc_sum[OUT_W-1:0];
      if (acc_sum[OUT_W]) begin
        acc_ovf_q <= 1'b1;
      end
    end
  end
`else
  logic unused_acc_ctrl;

  assign unused_acc_ctrl = in_acc ^ acc_clr;
  assign acc_ovf         = 1'b0;

  // every beat computes P + Ct
  always_comb begin
    y_next = s1_p + s1_ct;
  end
`endif

endmodule

// File: tb/tb_madd_trunc_pipe.sv
// Bench for madd_trunc_pipe: two instances (TRUNC=0 and TRUNC=4) share
// the stimulus; expected results go into per-instance queues when a
// beat is accepted and are popped when each instance presents a result.
module tb_madd_trunc_pipe;

  localparam int W  = 6;
  localparam int OW = 12;
`ifdef MADD_TRUNC_ACC_EN
  localparam bit ACC_ON = 1'b1;
`else
  localparam bit ACC_ON = 1'b0;
`endif

  typedef struct {
    logic [OW-1:0] y;
    logic          ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_a, in_b, in_c;
  logic          in_acc, acc_clr, out_ready;
  logic          in_ready0, out_valid0, acc_ovf0;
  logic          in_ready4, out_valid4, acc_ovf4;
  logic [OW-1:0] out_y0, out_y4;

  int   checks = 0;
  int   errors = 0;
  bit   rand_bp = 1'b0;
  exp_t q0[$];
  exp_t q4[$];

  always #5 clk = ~clk;

  madd_trunc_pipe #(.W(W), .TRUNC(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_acc(in_acc), .acc_clr(acc_clr),
    .out_valid(out_valid0), .out_ready(out_ready), .out_y(out_y0), .acc_ovf(acc_ovf0)
  );

  madd_trunc_pipe #(.W(W), .TRUNC(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_acc(in_acc), .acc_clr(acc_clr),
    .out_valid(out_valid4), .out_ready(out_ready), .out_y(out_y4), .acc_ovf(acc_ovf4)
  );

  function automatic logic [OW-1:0] ref_y(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c, input int t);
    int p;
    p = 0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (a[i] && b[j] && (i + j) >= t) p += (1 << (i + j));
    p += (int'(c) >> t) << t;
    return p[OW-1:0];
  endfunction

  // scoreboard: compare every consumed result against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_ready) begin
      if (out_valid0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL unexpected_u0 got y=%0d, no result was expected", out_y0);
        end else begin
          e = q0.pop_front();
          if (out_y0 !== e.y || acc_ovf0 !== e.ovf) begin
            errors++;
            $display("FAIL result_u0 got y=%0d ovf=%0b, expected y=%0d ovf=%0b", out_y0, acc_ovf0, e.y, e.ovf);
          end
        end
      end
      if (out_valid4) begin
        checks++;
        if (q4.size() == 0) begin
          errors++;
          $display("FAIL unexpected_u4 got y=%0d, no result was expected", out_y4);
        end else begin
          e = q4.pop_front();
          if (out_y4 !== e.y || acc_ovf4 !== e.ovf) begin
            errors++;
            $display("FAIL result_u4 got y=%0d ovf=%0b, expected y=%0d ovf=%0b", out_y4, acc_ovf4, e.y, e.ovf);
          end
        end
      end
    end
  end

  // random backpressure, enabled only during the random test
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Caller is aligned just after a rising edge; returns just after the accepting edge.
  task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                            input logic acc, input logic [OW-1:0] e0, input logic o0,
                            input logic [OW-1:0] e4, input logic o4);
    int n;
    exp_t x;
    in_valid = 1'b1; in_a = a; in_b = b; in_c = c; in_acc = acc;
    n = 0;
    @(negedge clk);
    while (!in_ready0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready0 || in_ready4 !== in_ready0) begin
      errors++;
      $display("FAIL accept got in_ready0=%0b in_ready4=%0b, expected both 1 within 50 cycles", in_ready0, in_ready4);
    end else begin
      x.y = e0; x.ovf = o0; q0.push_back(x);
      x.y = e4; x.ovf = o4; q4.push_back(x);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_acc   = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q4.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q0.size() != 0 || q4.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d results outstanding, expected 0/0", q0.size(), q4.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (acc_ovf0 !== 1'b0 || acc_ovf4 !== 1'b0) begin
      errors++;
      $display("FAIL acc_clr_ovf got %0b/%0b, expected 0/0", acc_ovf0, acc_ovf4);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0;
    in_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready0 !== 1'b1 || in_ready4 !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %0b/%0b, expected 1/1", in_ready0, in_ready4);
    end
    checks++;
    if (out_valid0 !== 1'b0 || out_valid4 !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %0b/%0b, expected 0/0", out_valid0, out_valid4);
    end
    checks++;
    if (out_y0 !== 12'd0 || out_y4 !== 12'd0) begin
      errors++; $display("FAIL reset_out_y got %0d/%0d, expected 0/0", out_y0, out_y4);
    end
    checks++;
    if (acc_ovf0 !== 1'b0 || acc_ovf4 !== 1'b0) begin
      errors++; $display("FAIL reset_acc_ovf got %0b/%0b, expected 0/0", acc_ovf0, acc_ovf4);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    drive_beat(6'd63, 6'd63, 6'd63, 1'b0, 12'd4032, 1'b0, 12'd3968, 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid0 !== 1'b0) begin
      errors++; $display("FAIL latency_early got out_valid=%0b one cycle after accept, expected 0", out_valid0);
    end
    @(negedge clk);
    checks++;
    if (out_valid0 !== 1'b1 || out_valid4 !== 1'b1) begin
      errors++; $display("FAIL latency_rise got out_valid=%0b/%0b, expected 1/1", out_valid0, out_valid4);
    end
    wait_drain();
  endtask

  task automatic test_trunc();
    drive_beat(6'd1,  6'd1, 6'd15, 1'b0, 12'd16, 1'b0, 12'd0,  1'b0);
    drive_beat(6'd16, 6'd1, 6'd0,  1'b0, 12'd16, 1'b0, 12'd16, 1'b0);
    drive_beat(6'd63, 6'd63, 6'd63, 1'b0, 12'd4032, 1'b0, 12'd3968, 1'b0);
    wait_drain();
  endtask

  task automatic test_accumulate();
    pulse_clr();
    for (int k = 1; k <= 4; k++) begin
      drive_beat(6'd10, 6'd10, 6'd0, 1'b1,
                 ACC_ON ? 12'(100 * k) : 12'd100, 1'b0,
                 ACC_ON ? 12'(96 * k)  : 12'd96,  1'b0);
    end
    wait_drain();
    checks++;
    if (acc_ovf0 !== 1'b0 || acc_ovf4 !== 1'b0) begin
      errors++; $display("FAIL accum_ovf got %0b/%0b, expected 0/0", acc_ovf0, acc_ovf4);
    end
  endtask

  task automatic test_overflow();
    pulse_clr();
    drive_beat(6'd63, 6'd63, 6'd0, 1'b1, 12'd3969, 1'b0, 12'd3920, 1'b0);
    drive_beat(6'd63, 6'd63, 6'd0, 1'b1,
               ACC_ON ? 12'd3842 : 12'd3969, ACC_ON,
               ACC_ON ? 12'd3744 : 12'd3920, ACC_ON);
    wait_drain();
    checks++;
    if (acc_ovf0 !== ACC_ON || acc_ovf4 !== ACC_ON) begin
      errors++; $display("FAIL ovf_sticky got %0b/%0b, expected %0b/%0b", acc_ovf0, acc_ovf4, ACC_ON, ACC_ON);
    end
    pulse_clr();
    drive_beat(6'd1, 6'd1, 6'd0, 1'b1, 12'd1, 1'b0, 12'd0, 1'b0);
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [W-1:0]  ba[4], bb[4], bc[4];
    logic [OW-1:0] hold;
    bit            have_hold, took;
    int            idx;
    exp_t          x;
    for (int k = 0; k < 4; k++) begin
      ba[k] = 6'(k + 3); bb[k] = 6'(k + 5); bc[k] = 6'(2 * k + 1);
    end
    out_ready = 1'b0;
    idx = 0; have_hold = 1'b0; hold = '0;
    in_valid = 1'b1; in_a = ba[0]; in_b = bb[0]; in_c = bc[0]; in_acc = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc == 8) out_ready = 1'b1;
      @(negedge clk);
      took = 1'b0;
      if (in_valid && in_ready0) begin
        x.y = ref_y(ba[idx], bb[idx], bc[idx], 0); x.ovf = 1'b0; q0.push_back(x);
        x.y = ref_y(ba[idx], bb[idx], bc[idx], 4); x.ovf = 1'b0; q4.push_back(x);
        took = 1'b1;
      end
      if (cyc < 8 && out_valid0) begin
        if (!have_hold) begin
          hold = out_y0; have_hold = 1'b1;
        end else begin
          checks++;
          if (out_y0 !== hold) begin
            errors++; $display("FAIL stall_stable got out_y=%0d, expected held %0d", out_y0, hold);
          end
        end
      end
      if (cyc >= 8) begin
        checks++;
        if (out_valid0 !== 1'b1) begin
          errors++; $display("FAIL drain_rate got out_valid=%0b at drain cycle %0d, expected 1", out_valid0, cyc - 8);
        end
      end
      if (cyc == 7) begin
        checks++;
        if (idx + int'(took) != 2 || in_ready0 !== 1'b0) begin
          errors++; $display("FAIL stall_accept got accepted=%0d in_ready=%0b, expected 2 and 0", idx + int'(took), in_ready0);
        end
      end
      @(posedge clk);
      #1;
      if (took) begin
        idx++;
        if (idx < 4) begin
          in_a = ba[idx]; in_b = bb[idx]; in_c = bc[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (idx != 4) begin
      errors++; $display("FAIL bp_total got %0d beats accepted, expected 4", idx);
    end
    wait_drain();
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, c;
    rand_bp = 1'b1;
    for (int k = 0; k < 24; k++) begin
      a = 6'($urandom_range(0, 63)); b = 6'($urandom_range(0, 63)); c = 6'($urandom_range(0, 63));
      drive_beat(a, b, c, 1'b0, ref_y(a, b, c, 0), 1'b0, ref_y(a, b, c, 4), 1'b0);
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    drive_beat(6'd10, 6'd10, 6'd0, 1'b1, 12'd100, 1'b0, 12'd96, 1'b0);
    drive_beat(6'd10, 6'd10, 6'd0, 1'b1, 12'd0, 1'b0, 12'd0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid0 !== 1'b0 || out_valid4 !== 1'b0 || out_y0 !== 12'd0 || in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got out_valid=%0b/%0b out_y=%0d in_ready=%0b, expected 0/0 0 1",
               out_valid0, out_valid4, out_y0, in_ready0);
    end
    q0.delete();
    q4.delete();
    out_ready = 1'b1;
    #3;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (out_valid0 !== 1'b0 || out_valid4 !== 1'b0) begin
      errors++; $display("FAIL stale_result got out_valid=%0b/%0b after reset, expected 0/0", out_valid0, out_valid4);
    end
    @(posedge clk);
    #1;
    drive_beat(6'd1, 6'd1, 6'd0, 1'b1, 12'd1, 1'b0, 12'd0, 1'b0);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_trunc();
    test_accumulate();
    test_overflow();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
